pipe_ltssm_detect_poll: RTL and testbench
=========================================

Name: pipe_ltssm_detect_poll

Overview:
Parametrised multi-lane LTSSM front end for an upstream PIPE MAC. It runs Detect.Quiet, Detect.Active, Polling.Active and Polling.Configuration across LANES lanes, with per-lane receiver detection and lane masking. It hands off to Configuration. It drives PIPE control outputs and requests TS1/TS2 transmission from the ordered-set generator. It consumes per-lane ordered-set strobes from the receive decoder.

Parameters:
LANES, 1, number of PIPE lanes (1..16)
T_QUIET, 1200000, Detect.Quiet timeout in pclk cycles (12 ms at 100 MHz)
T_ACTIVE, 2400000, Polling.Active and Polling.Configuration timeout in pclk cycles (24 ms)
TS1_TX_MIN, 1024, TS1 sets to transmit in Polling.Active
TS_RX_MIN, 8, consecutive TS received per lane needed to exit a polling substate
TS2_TX_MIN, 16, TS2 sets to transmit after the first TS2 is received on all masked lanes

Ports:
pclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  link training enable
PhyStatus  in  LANES  per-lane PHY completion pulse
RxStatus  in  3*LANES  per-lane status; lane i occupies [3i+2:3i]
RxElecIdle  in  LANES  per-lane receiver electrical idle
ts1_rx  in  LANES  one-cycle pulse per valid TS1 received
ts2_rx  in  LANES  one-cycle pulse per valid TS2 received
os_err  in  LANES  pulse on a non-TS or malformed ordered set; breaks consecutiveness
ts_tx_done  in  1  pulse per TS set transmitted
TxDetectRxorLpbk  out  1  receiver-detect request
PowerDown  out  2  power state (power_states encoding)
TxElecIdle  out  LANES  per-lane transmit electrical idle
ts_tx_req  out  1  request continuous TS transmission
ts_tx_type  out  1  0 = TS1, 1 = TS2
lane_mask  out  LANES  lanes on which a receiver was detected
ltssm_state  out  4  ltssm encoding
sub_state  out  3  substate code for the current ltssm_state
cfg_entry  out  1  one-cycle pulse on entry to Configuration

Behaviour:
- Reset values: ltssm_state=detect, sub_state=idle, PowerDown=P1, TxElecIdle=all 1, TxDetectRxorLpbk=0, ts_tx_req=0, ts_tx_type=0, lane_mask=0, cfg_entry=0. All counters reset to 0.
- en low in any state: go to Detect.Idle on the next cycle. Counters and lane_mask are cleared.
- Every state entry clears its timer and TS counters. Strobes in the transition cycle are ignored.
- Detect.Idle: on en=1, go to Detect.Quiet.
- Detect.Quiet: PowerDown=P1, TxElecIdle=all 1. Timer counts up. Go to Detect.Active when timer==T_QUIET-1 or any RxElecIdle bit is 0.
- Detect.Active: TxDetectRxorLpbk=1 until PhyStatus has been seen, as a sticky bit, on all LANES. Per lane, detected[i] is set when PhyStatus[i]=1 and RxStatus lane i==3'b011.
  - When all PhyStatus have been seen, drop TxDetectRxorLpbk.
  - If detected==0, go to Detect.Quiet. Otherwise set lane_mask=detected and go to Polling.Active.
  - Guard timeout of T_QUIET cycles also returns to Detect.Quiet.
- Polling.Active:
  - On entry, PowerDown=P0. Wait for a sticky PhyStatus on all masked lanes, then set TxElecIdle[i]=~lane_mask[i] and ts_tx_req=1 with ts_tx_type=0.
  - tx_cnt increments on ts_tx_done and saturates at TS1_TX_MIN.
  - Per masked lane, rx_cnt increments on ts1_rx|ts2_rx, saturates at TS_RX_MIN, and is cleared by os_err. If os_err and a TS strobe arrive together, the count is cleared.
  - Exit to Polling.Configuration when tx_cnt==TS1_TX_MIN and every masked lane has rx_cnt==TS_RX_MIN.
  - Timeout at T_ACTIVE-1 returns to Detect.Quiet. If exit and timeout occur in the same cycle, exit wins.
- Polling.Configuration:
  - ts_tx_type=1. Per lane, count consecutive ts2_rx; both ts1_rx and os_err clear the count.
  - tx_cnt counts ts_tx_done only after ts2_rx has been seen on all masked lanes (sticky).
  - Exit to Configuration when tx_cnt==TS2_TX_MIN and all masked lanes have count==TS_RX_MIN.
  - Timeout at T_ACTIVE-1 returns to Detect.Quiet; exit wins on a tie.
- Configuration (handoff): ltssm_state=configuration, sub_state=conf_linkwidth_start, ts_tx_req=0. cfg_entry pulses for one cycle. Remain here until en=0.
- Unmasked lanes are ignored in every condition. They keep TxElecIdle=1.
- All outputs are registered; latency is one cycle from a condition to the output change.
- Timer width is $clog2(max(T_QUIET, T_ACTIVE)). Counter width is $clog2(max(TS1_TX_MIN, TS2_TX_MIN) + 1).

Decomposition:
- pipe_pkg additions:
  - RXSTAT_RX_DETECTED = 3'b011.
  - Timeout localparams, reused as parameter defaults.
  - ltssm, detect_sub and polling_sub enums, reused for ltssm_state and sub_state.
- Sub-module pipe_ts_lane_counter: per-lane saturating consecutive-TS counter (inc, clr, sat_flag). Instantiated LANES times via generate.

Test Plan:
- LANES=4, T_QUIET=100, all RxElecIdle=1, PhyStatus with RxStatus=3'b011 on lanes 0 and 2 only -> Detect.Active is entered at cycle 100, lane_mask=4'b0101, then Polling.Active.
- All lanes report RxStatus=3'b000 in Detect.Active -> return to Detect.Quiet and lane_mask=0; the timer restarts from 0.
- Polling.Active with TS1_TX_MIN=16 and TS_RX_MIN=8: 16 ts_tx_done and 8 ts1_rx per masked lane -> Polling.Configuration with ts_tx_type=1. An os_err on lane 2 after 7 TS -> no exit until 8 further TS on lane 2.
- Polling.Configuration: 8 ts2_rx per lane, then 16 ts_tx_done -> Configuration and a single-cycle cfg_entry. ts_tx_done pulses before all lanes have seen ts2_rx are not counted.
- T_ACTIVE=200 with no ts1_rx -> Detect.Quiet at cycle 200 of Polling.Active. Exit condition and timeout forced in the same cycle -> Polling.Configuration.
- en dropped in Polling.Active -> Detect.Idle next cycle, TxElecIdle=all 1, ts_tx_req=0. rst_n asserted mid-state -> all reset values immediately.

Source files
------------

// File: rtl/pipe_ltssm_detect_poll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ltssm_detect_poll_pkg
// Description : Shared encodings and defaults for the Detect/Polling LTSSM
//               front end (LTSSM states, substates, power states, timeouts).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ltssm_detect_poll_pkg;

  // RxStatus code reported with PhyStatus when a far-end receiver is present
  localparam logic [2:0] RXSTAT_RX_DETECTED = 3'b011;

  // Timeouts in pclk cycles at 100 MHz, and ordered-set count thresholds
  localparam int T_QUIET_DEF    = 1200000;
  localparam int T_ACTIVE_DEF   = 2400000;
  localparam int TS1_TX_MIN_DEF = 1024;
  localparam int TS_RX_MIN_DEF  = 8;
  localparam int TS2_TX_MIN_DEF = 16;

  typedef enum logic [3:0] {
    LTSSM_DETECT        = 4'd0,
    LTSSM_POLLING       = 4'd1,
    LTSSM_CONFIGURATION = 4'd2
  } ltssm_e;

  typedef enum logic [2:0] {
    DET_IDLE   = 3'd0,
    DET_QUIET  = 3'd1,
    DET_ACTIVE = 3'd2
  } detect_sub_e;

  typedef enum logic [2:0] {
    POLL_ACTIVE        = 3'd0,
    POLL_CONFIGURATION = 3'd1
  } polling_sub_e;

  typedef enum logic [2:0] {
    CONF_LINKWIDTH_START = 3'd0
  } config_sub_e;

  typedef enum logic [1:0] {
    PWR_P0  = 2'b00,
    PWR_P0S = 2'b01,
    PWR_P1  = 2'b10,
    PWR_P2  = 2'b11
  } power_states_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ts_lane_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ts_lane_counter
// Description : Per-lane saturating counter of consecutive training sets.
//               Clear wins over increment when both occur in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ts_lane_counter
  import pipe_ltssm_detect_poll_pkg::*;
#(
  parameter int SAT_VAL = TS_RX_MIN_DEF
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int            CW    = $clog2(SAT_VAL + 1);
  localparam logic [CW-1:0] c_sat = CW'(SAT_VAL);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear dominates, otherwise count up to the saturation value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != c_sat)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == c_sat);

endmodule
`default_nettype wire

// File: rtl/pipe_ltssm_detect_poll.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ltssm_detect_poll
// Description : Multi-lane LTSSM front end: Detect.Quiet/Active,
//               Polling.Active/Configuration, hand-off to Configuration.
//               All outputs come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ltssm_detect_poll
  import pipe_ltssm_detect_poll_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int T_QUIET    = T_QUIET_DEF,
  parameter int T_ACTIVE   = T_ACTIVE_DEF,
  parameter int TS1_TX_MIN = TS1_TX_MIN_DEF,
  parameter int TS_RX_MIN  = TS_RX_MIN_DEF,
  parameter int TS2_TX_MIN = TS2_TX_MIN_DEF
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [LANES-1:0]   PhyStatus,
  input  logic [3*LANES-1:0] RxStatus,
  input  logic [LANES-1:0]   RxElecIdle,
  input  logic [LANES-1:0]   ts1_rx,
  input  logic [LANES-1:0]   ts2_rx,
  input  logic [LANES-1:0]   os_err,
  input  logic               ts_tx_done,
  output logic               TxDetectRxorLpbk,
  output logic [1:0]         PowerDown,
  output logic [LANES-1:0]   TxElecIdle,
  output logic               ts_tx_req,
  output logic               ts_tx_type,
  output logic [LANES-1:0]   lane_mask,
  output logic [3:0]         ltssm_state,
  output logic [2:0]         sub_state,
  output logic               cfg_entry
);

  localparam int TW = $clog2(max_i(T_QUIET, T_ACTIVE));
  localparam int CW = $clog2(max_i(TS1_TX_MIN, TS2_TX_MIN) + 1);

  localparam logic [TW-1:0] c_tq_last = TW'(T_QUIET - 1);
  localparam logic [TW-1:0] c_ta_last = TW'(T_ACTIVE - 1);
  localparam logic [CW-1:0] c_ts1_min = CW'(TS1_TX_MIN);
  localparam logic [CW-1:0] c_ts2_min = CW'(TS2_TX_MIN);

  localparam logic [2:0] c_st_det_idle   = 3'd0;
  localparam logic [2:0] c_st_det_quiet  = 3'd1;
  localparam logic [2:0] c_st_det_active = 3'd2;
  localparam logic [2:0] c_st_poll_act   = 3'd3;
  localparam logic [2:0] c_st_poll_cfg   = 3'd4;
  localparam logic [2:0] c_st_config     = 3'd5;

  logic [2:0]       st_q, st_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [LANES-1:0] phy_seen_q, phy_seen_d;
  logic [LANES-1:0] detected_q, detected_d;
  logic [LANES-1:0] ts2_seen_q, ts2_seen_d;
  logic [LANES-1:0] lane_mask_q, lane_mask_d;

  logic [3:0]       ltssm_q, ltssm_d;
  logic [2:0]       sub_q, sub_d;
  logic [1:0]       pd_q, pd_d;
  logic [LANES-1:0] txei_q, txei_d;
  logic             txdet_q, txdet_d;
  logic             req_q, req_d;
  logic             type_q, type_d;
  logic             cfg_q, cfg_d;

  logic [LANES-1:0] w_rx_det;
  logic [LANES-1:0] w_lane_inc, w_lane_clr, w_lane_sat;
  logic [LANES-1:0] w_phy_now, w_det_now;
  logic             w_mask_sat, w_ts2_all, w_tq_hit, w_ta_hit;

  // Per-lane receiver-detect decode and consecutive-TS counters
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_rx_det[i] = (RxStatus[3*i +: 3] == RXSTAT_RX_DETECTED);

    pipe_ts_lane_counter #(
      .SAT_VAL (TS_RX_MIN)
    ) u_ts_cnt (
      .pclk  (pclk),
      .rst_n (rst_n),
      .inc_i (w_lane_inc[i]),
      .clr_i (w_lane_clr[i]),
      .sat_o (w_lane_sat[i])
    );
  end

  assign w_phy_now  = phy_seen_q | PhyStatus;
  assign w_det_now  = detected_q | (PhyStatus & w_rx_det);
  assign w_mask_sat = &(w_lane_sat | ~lane_mask_q);
  assign w_ts2_all  = &(ts2_seen_q | ~lane_mask_q);
  assign w_tq_hit   = (timer_q == c_tq_last);
  assign w_ta_hit   = (timer_q == c_ta_last);

  // State transitions, timers and counters; any state change restarts them
  always_comb begin
    st_d        = st_q;
    timer_d     = timer_q;
    tx_cnt_d    = tx_cnt_q;
    phy_seen_d  = phy_seen_q;
    detected_d  = detected_q;
    ts2_seen_d  = ts2_seen_q;
    lane_mask_d = lane_mask_q;
    w_lane_inc  = '0;
    w_lane_clr  = '0;

    case (st_q)
      c_st_det_idle: begin
        if (en) st_d = c_st_det_quiet;
      end
      c_st_det_quiet: begin
        timer_d = timer_q + TW'(1);
        if (w_tq_hit || !(&RxElecIdle)) st_d = c_st_det_active;
      end
      c_st_det_active: begin
        timer_d    = timer_q + TW'(1);
        phy_seen_d = w_phy_now;
        detected_d = w_det_now;
        // Detection result takes precedence over the guard timeout
        if (&w_phy_now) begin
          if (w_det_now == '0) begin
            st_d = c_st_det_quiet;
          end else begin
            lane_mask_d = w_det_now;
            st_d        = c_st_poll_act;
          end
        end else if (w_tq_hit) begin
          st_d = c_st_det_quiet;
        end
      end
      c_st_poll_act: begin
        timer_d    = timer_q + TW'(1);
        phy_seen_d = phy_seen_q | (PhyStatus & lane_mask_q);
        if (ts_tx_done && (tx_cnt_q != c_ts1_min)) tx_cnt_d = tx_cnt_q + CW'(1);
        w_lane_inc = (ts1_rx | ts2_rx) & lane_mask_q;
        w_lane_clr = os_err & lane_mask_q;
        if ((tx_cnt_q == c_ts1_min) && w_mask_sat) begin
          st_d = c_st_poll_cfg;
        end else if (w_ta_hit) begin
          st_d = c_st_det_quiet;
        end
      end
      c_st_poll_cfg: begin
        timer_d    = timer_q + TW'(1);
        ts2_seen_d = ts2_seen_q | (ts2_rx & lane_mask_q);
        // TS2 transmit credit only starts once every lane has heard a TS2
        if (ts_tx_done && w_ts2_all && (tx_cnt_q != c_ts2_min)) tx_cnt_d = tx_cnt_q + CW'(1);
        w_lane_inc = ts2_rx & lane_mask_q;
        w_lane_clr = (ts1_rx | os_err) & lane_mask_q;
        if ((tx_cnt_q == c_ts2_min) && w_mask_sat) begin
          st_d = c_st_config;
        end else if (w_ta_hit) begin
          st_d = c_st_det_quiet;
        end
      end
      c_st_config: begin
        st_d = c_st_config;
      end
      default: begin
        st_d = c_st_det_idle;
      end
    endcase

    if (!en) st_d = c_st_det_idle;

    if (st_d != st_q) begin
      timer_d    = '0;
      tx_cnt_d   = '0;
      phy_seen_d = '0;
      detected_d = '0;
      ts2_seen_d = '0;
      w_lane_inc = '0;
      w_lane_clr = '1;
    end

    if ((st_d == c_st_det_idle) || (st_d == c_st_det_quiet)) lane_mask_d = '0;
  end

  // Output values for the state being entered, so outputs track state exactly
  always_comb begin
    ltssm_d = LTSSM_DETECT;
    sub_d   = DET_IDLE;
    pd_d    = PWR_P1;
    txei_d  = '1;
    txdet_d = 1'b0;
    req_d   = 1'b0;
    type_d  = 1'b0;
    cfg_d   = (st_d == c_st_config) && (st_q != c_st_config);
    case (st_d)
      c_st_det_quiet: sub_d = DET_QUIET;
      c_st_det_active: begin
        sub_d   = DET_ACTIVE;
        txdet_d = ~(&phy_seen_d);
      end
      c_st_poll_act: begin
        ltssm_d = LTSSM_POLLING;
        sub_d   = POLL_ACTIVE;
        pd_d    = PWR_P0;
        if (&(phy_seen_d | ~lane_mask_d)) begin
          txei_d = ~lane_mask_d;
          req_d  = 1'b1;
        end
      end
      c_st_poll_cfg: begin
        ltssm_d = LTSSM_POLLING;
        sub_d   = POLL_CONFIGURATION;
        pd_d    = PWR_P0;
        txei_d  = ~lane_mask_d;
        req_d   = 1'b1;
        type_d  = 1'b1;
      end
      c_st_config: begin
        ltssm_d = LTSSM_CONFIGURATION;
        sub_d   = CONF_LINKWIDTH_START;
        pd_d    = PWR_P0;
        txei_d  = ~lane_mask_d;
      end
      default: ;
    endcase
  end

  // State, timer and counter registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= c_st_det_idle;
      timer_q     <= '0;
      tx_cnt_q    <= '0;
      phy_seen_q  <= '0;
      detected_q  <= '0;
      ts2_seen_q  <= '0;
      lane_mask_q <= '0;
    end else begin
      st_q        <= st_d;
      timer_q     <= timer_d;
      tx_cnt_q    <= tx_cnt_d;
      phy_seen_q  <= phy_seen_d;
      detected_q  <= detected_d;
      ts2_seen_q  <= ts2_seen_d;
      lane_mask_q <= lane_mask_d;
    end
  end

  // Output registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      ltssm_q <= LTSSM_DETECT;
      sub_q   <= DET_IDLE;
      pd_q    <= PWR_P1;
      txei_q  <= '1;
      txdet_q <= 1'b0;
      req_q   <= 1'b0;
      type_q  <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      ltssm_q <= ltssm_d;
      sub_q   <= sub_d;
      pd_q    <= pd_d;
      txei_q  <= txei_d;
      txdet_q <= txdet_d;
      req_q   <= req_d;
      type_q  <= type_d;
      cfg_q   <= cfg_d;
    end
  end

  assign TxDetectRxorLpbk = txdet_q;
  assign PowerDown        = pd_q;
  assign TxElecIdle       = txei_q;
  assign ts_tx_req        = req_q;
  assign ts_tx_type       = type_q;
  assign lane_mask        = lane_mask_q;
  assign ltssm_state      = ltssm_q;
  assign sub_state        = sub_q;
  assign cfg_entry        = cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ltssm_detect_poll.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ltssm_detect_poll
// Description : Directed bench for the Detect/Polling LTSSM front end with
//               a queue of expected output snapshots.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ltssm_detect_poll;
  import pipe_ltssm_detect_poll_pkg::*;

  logic       pclk = 1'b0;
  logic       rst_n, en, ts_tx_done;
  logic [3:0] PhyStatus, RxElecIdle, ts1_rx, ts2_rx, os_err;
  logic [11:0] RxStatus;
  logic       TxDetectRxorLpbk, ts_tx_req, ts_tx_type, cfg_entry;
  logic [1:0] PowerDown;
  logic [3:0] TxElecIdle, lane_mask, ltssm_state;
  logic [2:0] sub_state;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] sub;
    logic [3:0] mask;
    logic [1:0] pd;
    logic [3:0] txei;
    logic       det;
    logic       req;
    logic       typ;
    logic       cfg;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  pipe_ltssm_detect_poll #(
    .LANES      (4),
    .T_QUIET    (100),
    .T_ACTIVE   (200),
    .TS1_TX_MIN (16),
    .TS_RX_MIN  (8),
    .TS2_TX_MIN (16)
  ) dut (
    .pclk             (pclk),
    .rst_n            (rst_n),
    .en               (en),
    .PhyStatus        (PhyStatus),
    .RxStatus         (RxStatus),
    .RxElecIdle       (RxElecIdle),
    .ts1_rx           (ts1_rx),
    .ts2_rx           (ts2_rx),
    .os_err           (os_err),
    .ts_tx_done       (ts_tx_done),
    .TxDetectRxorLpbk (TxDetectRxorLpbk),
    .PowerDown        (PowerDown),
    .TxElecIdle       (TxElecIdle),
    .ts_tx_req        (ts_tx_req),
    .ts_tx_type       (ts_tx_type),
    .lane_mask        (lane_mask),
    .ltssm_state      (ltssm_state),
    .sub_state        (sub_state),
    .cfg_entry        (cfg_entry)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic step(input logic [3:0] t1, input logic [3:0] t2,
                      input logic [3:0] er, input logic dn);
    ts1_rx = t1; ts2_rx = t2; os_err = er; ts_tx_done = dn;
    tick();
    ts1_rx = '0; ts2_rx = '0; os_err = '0; ts_tx_done = 1'b0;
  endtask

  task automatic cmp(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic exp_out(input string tag, input logic [3:0] st, input logic [2:0] sub,
                         input logic [3:0] mask, input logic [1:0] pd, input logic [3:0] txei,
                         input logic det, input logic req, input logic typ, input logic cfg);
    exp_t e;
    e.st = st; e.sub = sub; e.mask = mask; e.pd = pd; e.txei = txei;
    e.det = det; e.req = req; e.typ = typ; e.cfg = cfg;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic chk();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "ltssm_state", 32'(ltssm_state), 32'(e.st));
      cmp(t, "sub_state",   32'(sub_state),   32'(e.sub));
      cmp(t, "lane_mask",   32'(lane_mask),   32'(e.mask));
      cmp(t, "PowerDown",   32'(PowerDown),   32'(e.pd));
      cmp(t, "TxElecIdle",  32'(TxElecIdle),  32'(e.txei));
      cmp(t, "TxDetect",    32'(TxDetectRxorLpbk), 32'(e.det));
      cmp(t, "ts_tx_req",   32'(ts_tx_req),   32'(e.req));
      cmp(t, "ts_tx_type",  32'(ts_tx_type),  32'(e.typ));
      cmp(t, "cfg_entry",   32'(cfg_entry),   32'(e.cfg));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; PhyStatus = '0; RxStatus = '0; RxElecIdle = '1;
    ts1_rx = '0; ts2_rx = '0; os_err = '0; ts_tx_done = 1'b0;
    ticks(3);
    exp_out("reset", LTSSM_DETECT, DET_IDLE, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); chk();
    rst_n = 1'b1;
    exp_out("idle_no_en", LTSSM_DETECT, DET_IDLE, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();

    // Detect.Quiet times out after exactly 100 cycles
    en = 1'b1;
    exp_out("quiet_entry", LTSSM_DETECT, DET_QUIET, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();
    ticks(98);
    exp_out("quiet_c99", LTSSM_DETECT, DET_QUIET, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();
    exp_out("active_c100", LTSSM_DETECT, DET_ACTIVE, 4'h0, PWR_P1, 4'hF, 1, 0, 0, 0); tick(); chk();

    // No receivers: back to Detect.Quiet with a fresh timer
    PhyStatus = 4'hF; RxStatus = '0;
    exp_out("nodet_quiet", LTSSM_DETECT, DET_QUIET, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();
    PhyStatus = '0;
    ticks(98);
    exp_out("requiet_c99", LTSSM_DETECT, DET_QUIET, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();
    exp_out("reactive_c100", LTSSM_DETECT, DET_ACTIVE, 4'h0, PWR_P1, 4'hF, 1, 0, 0, 0); tick(); chk();

    // Receivers on lanes 0 and 2
    PhyStatus = 4'hF; RxStatus = {3'b000, 3'b011, 3'b000, 3'b011};
    exp_out("det_0101", LTSSM_POLLING, POLL_ACTIVE, 4'b0101, PWR_P0, 4'hF, 0, 0, 0, 0); tick(); chk();
    PhyStatus = '0; RxStatus = '0;
    PhyStatus = 4'b0101;
    exp_out("pa_tx_on", LTSSM_POLLING, POLL_ACTIVE, 4'b0101, PWR_P0, 4'b1010, 0, 1, 0, 0); tick(); chk();
    PhyStatus = '0;

    // 7 TS1 on both lanes, then os_err+TS1 on lane 2 restarts its count
    for (int i = 0; i < 7; i++) step(4'b0101, 4'h0, 4'h0, 1'b1);
    step(4'b0101, 4'h0, 4'b0100, 1'b1);
    for (int i = 0; i < 7; i++) step(4'b0100, 4'h0, 4'b0010, 1'b1);
    step(4'h0, 4'h0, 4'h0, 1'b1);
    exp_out("pa_lane2_7", LTSSM_POLLING, POLL_ACTIVE, 4'b0101, PWR_P0, 4'b1010, 0, 1, 0, 0); tick(); chk();
    exp_out("pa_lane2_8", LTSSM_POLLING, POLL_ACTIVE, 4'b0101, PWR_P0, 4'b1010, 0, 1, 0, 0);
    step(4'b0100, 4'h0, 4'h0, 1'b0); chk();
    exp_out("pa_to_pc", LTSSM_POLLING, POLL_CONFIGURATION, 4'b0101, PWR_P0, 4'b1010, 0, 1, 1, 0); tick(); chk();

    // TS2 only on lane 0: transmit completions are not credited yet
    for (int i = 0; i < 8; i++) step(4'h0, 4'b0001, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(4'h0, 4'b0100, 4'h0, 1'b0);
    for (int i = 0; i < 15; i++) step(4'h0, 4'h0, 4'h0, 1'b1);
    exp_out("pc_tx15", LTSSM_POLLING, POLL_CONFIGURATION, 4'b0101, PWR_P0, 4'b1010, 0, 1, 1, 0); tick(); chk();
    exp_out("pc_tx16", LTSSM_POLLING, POLL_CONFIGURATION, 4'b0101, PWR_P0, 4'b1010, 0, 1, 1, 0);
    step(4'h0, 4'h0, 4'h0, 1'b1); chk();
    exp_out("cfg_entry", LTSSM_CONFIGURATION, CONF_LINKWIDTH_START, 4'b0101, PWR_P0, 4'b1010, 0, 0, 0, 1); tick(); chk();
    exp_out("cfg_hold", LTSSM_CONFIGURATION, CONF_LINKWIDTH_START, 4'b0101, PWR_P0, 4'b1010, 0, 0, 0, 0); tick(); chk();

    // Polling.Active timeout with all four lanes present
    en = 1'b0;
    exp_out("cfg_en_off", LTSSM_DETECT, DET_IDLE, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();
    en = 1'b1;
    exp_out("to_quiet", LTSSM_DETECT, DET_QUIET, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();
    RxElecIdle = 4'b1110;
    exp_out("to_active", LTSSM_DETECT, DET_ACTIVE, 4'h0, PWR_P1, 4'hF, 1, 0, 0, 0); tick(); chk();
    RxElecIdle = '1; PhyStatus = 4'hF; RxStatus = {4{3'b011}};
    exp_out("to_pa", LTSSM_POLLING, POLL_ACTIVE, 4'hF, PWR_P0, 4'hF, 0, 0, 0, 0); tick(); chk();
    PhyStatus = '0; RxStatus = '0;
    ticks(198);
    exp_out("to_pa_c199", LTSSM_POLLING, POLL_ACTIVE, 4'hF, PWR_P0, 4'hF, 0, 0, 0, 0); tick(); chk();
    exp_out("to_quiet_c200", LTSSM_DETECT, DET_QUIET, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();

    // Exit condition coincides with the timeout: exit wins
    RxElecIdle = 4'b1110;
    exp_out("tie_active", LTSSM_DETECT, DET_ACTIVE, 4'h0, PWR_P1, 4'hF, 1, 0, 0, 0); tick(); chk();
    RxElecIdle = '1; PhyStatus = 4'hF; RxStatus = {4{3'b011}};
    exp_out("tie_pa", LTSSM_POLLING, POLL_ACTIVE, 4'hF, PWR_P0, 4'hF, 0, 0, 0, 0); tick(); chk();
    PhyStatus = '0; RxStatus = '0;
    ticks(183);
    for (int i = 0; i < 15; i++) step(4'hF, 4'h0, 4'h0, 1'b1);
    exp_out("tie_pa_c199", LTSSM_POLLING, POLL_ACTIVE, 4'hF, PWR_P0, 4'hF, 0, 0, 0, 0);
    step(4'hF, 4'h0, 4'h0, 1'b1); chk();
    exp_out("tie_exit_wins", LTSSM_POLLING, POLL_CONFIGURATION, 4'hF, PWR_P0, 4'h0, 0, 1, 1, 0); tick(); chk();

    // en dropped in Polling.Active
    en = 1'b0;
    exp_out("pc_en_off", LTSSM_DETECT, DET_IDLE, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();
    en = 1'b1;
    tick();
    RxElecIdle = 4'b1110; tick(); RxElecIdle = '1;
    PhyStatus = 4'hF; RxStatus = {4{3'b011}}; tick(); RxStatus = '0;
    exp_out("pa2_tx_on", LTSSM_POLLING, POLL_ACTIVE, 4'hF, PWR_P0, 4'h0, 0, 1, 0, 0); tick(); chk();
    PhyStatus = '0;
    en = 1'b0;
    exp_out("pa_en_off", LTSSM_DETECT, DET_IDLE, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0); tick(); chk();

    // Asynchronous reset in the middle of Polling.Active
    en = 1'b1;
    tick();
    RxElecIdle = 4'b1110; tick(); RxElecIdle = '1;
    PhyStatus = 4'hF; RxStatus = {4{3'b011}}; tick(); RxStatus = '0;
    exp_out("pa3_tx_on", LTSSM_POLLING, POLL_ACTIVE, 4'hF, PWR_P0, 4'h0, 0, 1, 0, 0); tick(); chk();
    PhyStatus = '0;
    #2;
    rst_n = 1'b0;
    exp_out("async_reset", LTSSM_DETECT, DET_IDLE, 4'h0, PWR_P1, 4'hF, 0, 0, 0, 0);
    #1; chk();
    ticks(2);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
